// File: rtl/mprj2_enable_seq.sv
// mprj2 power-domain enable sequencer: qualifies supply, releases isolation and user enables in order.
// Define MPRJ2_SEQ_FAULT_CNT_EN to add the saturating fault event counter on fault_cnt_o.
module mprj2_enable_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP_CYCLES     = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       pwr_good_i,
    input  logic       hi_tie_i,
    input  logic       sw_enable_i,
    input  logic       fault_clr_i,
    output logic       iso_n_o,
    output logic       ena_wb_o,
    output logic       ena_la_o,
    output logic       ena_irq_o,
    output logic       busy_o,
    output logic       fault_o,
`ifdef MPRJ2_SEQ_FAULT_CNT_EN
    output logic [7:0] fault_cnt_o,
`endif
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_ISO_REL  = 3'd2,
        S_WB_ON    = 3'd3,
        S_LA_ON    = 3'd4,
        S_RUN      = 3'd5,
        S_SHUTDOWN = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       phase_q;
    logic             pg_meta_q, pg_s_q;
    logic             iso_q, wb_q, la_q, irq_q, busy_q, fault_q;

    logic             qual;
    logic             fault_ev;
    logic             step_done;
    logic [CNT_W-1:0] cnt_inc;

    assign qual      = pg_s_q & hi_tie_i;
    // Supply loss only counts as a fault once isolation may have been released.
    assign fault_ev  = ~qual & (state_q != S_OFF) & (state_q != S_DEBOUNCE);
    assign step_done = (cnt_q == STEP_LAST);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            phase_q   <= 2'd0;
            pg_meta_q <= 1'b0;
            pg_s_q    <= 1'b0;
            iso_q     <= 1'b0;
            wb_q      <= 1'b0;
            la_q      <= 1'b0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pg_meta_q <= pwr_good_i;
            pg_s_q    <= pg_meta_q;
            if (fault_clr_i) fault_q <= 1'b0;
            if (fault_ev) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
                phase_q <= 2'd0;
                iso_q   <= 1'b0;
                wb_q    <= 1'b0;
                la_q    <= 1'b0;
                irq_q   <= 1'b0;
                busy_q  <= 1'b0;
                fault_q <= 1'b1;
            end else begin
                unique case (state_q)
                    S_OFF: begin
                        if (sw_enable_i && qual && !fault_q) begin
                            state_q <= S_DEBOUNCE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (!qual || !sw_enable_i) begin
                            state_q <= S_OFF;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= S_ISO_REL;
                            cnt_q   <= '0;
                            iso_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_ISO_REL, S_WB_ON, S_LA_ON: begin
                        if (!sw_enable_i) begin
                            state_q <= S_SHUTDOWN;
                            cnt_q   <= '0;
                            phase_q <= 2'd0;
                            irq_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (step_done) begin
                            cnt_q <= '0;
                            if (state_q == S_ISO_REL) begin
                                state_q <= S_WB_ON;
                                wb_q    <= 1'b1;
                            end else if (state_q == S_WB_ON) begin
                                state_q <= S_LA_ON;
                                la_q    <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                                irq_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_RUN: begin
                        if (!sw_enable_i) begin
                            state_q <= S_SHUTDOWN;
                            cnt_q   <= '0;
                            phase_q <= 2'd0;
                            irq_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_SHUTDOWN: begin
                        // Each phase drops one more enable; phase 3 only waits before OFF.
                        if (step_done) begin
                            cnt_q   <= '0;
                            phase_q <= phase_q + 2'd1;
                            unique case (phase_q)
                                2'd0: la_q  <= 1'b0;
                                2'd1: wb_q  <= 1'b0;
                                2'd2: iso_q <= 1'b0;
                                default: begin
                                    state_q <= S_OFF;
                                    busy_q  <= 1'b0;
                                end
                            endcase
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= S_OFF;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MPRJ2_SEQ_FAULT_CNT_EN
    logic [7:0] fault_cnt_q;

    // Counts every fault event, even while fault_o is still set.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            fault_cnt_q <= 8'd0;
        end else if (fault_ev && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end

    assign fault_cnt_o = fault_cnt_q;
`endif

    assign iso_n_o   = iso_q;
    assign ena_wb_o  = wb_q;
    assign ena_la_o  = la_q;
    assign ena_irq_o = irq_q;
    assign busy_o    = busy_q;
    assign fault_o   = fault_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mprj2_enable_seq.sv
// Directed bench for mprj2_enable_seq: expectations are queued with a target cycle and checked by a monitor.
module tb_mprj2_enable_seq;

    logic       clk = 1'b0;
    logic       rst, pg, hi, sw, clr;
    logic       iso, wb, la, irq, busy, fault;
    logic [2:0] state;
    logic [7:0] cnt_obs;
    logic [8:0] obs;

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [8:0]  exp;
        bit          chk_cnt;
        logic [7:0]  cnt;
    } sb_t;

    sb_t         sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef MPRJ2_SEQ_FAULT_CNT_EN
    logic [7:0] fault_cnt;
    assign cnt_obs = fault_cnt;
`else
    assign cnt_obs = 8'd0;
`endif

    mprj2_enable_seq dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .pwr_good_i  (pg),
        .hi_tie_i    (hi),
        .sw_enable_i (sw),
        .fault_clr_i (clr),
        .iso_n_o     (iso),
        .ena_wb_o    (wb),
        .ena_la_o    (la),
        .ena_irq_o   (irq),
        .busy_o      (busy),
        .fault_o     (fault),
`ifdef MPRJ2_SEQ_FAULT_CNT_EN
        .fault_cnt_o (fault_cnt),
`endif
        .state_o     (state)
    );

    assign obs = {iso, wb, la, irq, busy, fault, state};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose cycle has arrived.
    initial begin : monitor
        sb_t ent;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                ent = sb.pop_front();
                vectors++;
                assert (obs === ent.exp) else begin
                    miscompares++;
                    $error("FAIL %s cyc=%0d observed={iso,wb,la,irq,busy,fault,st}=%b expected=%b",
                           ent.tag, cyc, obs, ent.exp);
                end
                if (ent.chk_cnt) begin
                    vectors++;
                    assert (cnt_obs === ent.cnt) else begin
                        miscompares++;
                        $error("FAIL %s_cnt cyc=%0d observed=%0d expected=%0d", ent.tag, cyc, cnt_obs, ent.cnt);
                    end
                end
            end
        end
    end

    function automatic logic [8:0] v(input logic i_iso, i_wb, i_la, i_irq, i_busy, i_fault,
                                     input logic [2:0] st);
        return {i_iso, i_wb, i_la, i_irq, i_busy, i_fault, st};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_at(input int unsigned d, input string tag, input logic [8:0] e);
        sb.push_back('{cyc: cyc + d, tag: tag, exp: e, chk_cnt: 1'b0, cnt: 8'd0});
    endtask

    task automatic exp_cnt(input int unsigned d, input string tag, input logic [8:0] e, input logic [7:0] c);
        sb.push_back('{cyc: cyc + d, tag: tag, exp: e, chk_cnt: 1'b1, cnt: c});
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations pending at cyc %0d, required 0", sb.size(), cyc);
            $fatal(1, "scoreboard stalled");
        end
    endtask

    // Clear a latched fault with sw_enable/qual held high and follow the full power-up to RUN.
    task automatic clear_and_run(input string tag);
        clr = 1'b1;
        exp_at(1, {tag, "_clr"}, v(0, 0, 0, 0, 0, 0, 3'd0));
        tick(1);
        clr = 1'b0;
        exp_at(1, {tag, "_deb"}, v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(17, {tag, "_iso"}, v(1, 0, 0, 0, 1, 0, 3'd2));
        exp_at(29, {tag, "_run"}, v(1, 1, 1, 1, 0, 0, 3'd5));
        drain();
    endtask

    initial begin
        rst = 1'b1; pg = 1'b0; hi = 1'b0; sw = 1'b0; clr = 1'b0;
        tick(2);
        exp_at(1, "reset", v(0, 0, 0, 0, 0, 0, 3'd0));
        drain();
        rst = 1'b0;

        // Power-up: E_k is d = k + 1.
        sw = 1'b1; hi = 1'b1; pg = 1'b1;
        exp_at(2,  "pu_e1_off",   v(0, 0, 0, 0, 0, 0, 3'd0));
        exp_at(3,  "pu_e2_deb",   v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(18, "pu_e17_deb",  v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(19, "pu_e18_iso",  v(1, 0, 0, 0, 1, 0, 3'd2));
        exp_at(22, "pu_e21_iso",  v(1, 0, 0, 0, 1, 0, 3'd2));
        exp_at(23, "pu_e22_wb",   v(1, 1, 0, 0, 1, 0, 3'd3));
        exp_at(27, "pu_e26_la",   v(1, 1, 1, 0, 1, 0, 3'd4));
        exp_at(30, "pu_e29_la",   v(1, 1, 1, 0, 1, 0, 3'd4));
        exp_at(31, "pu_e30_run",  v(1, 1, 1, 1, 0, 0, 3'd5));
        exp_at(41, "pu_run_hold", v(1, 1, 1, 1, 0, 0, 3'd5));
        drain();

        // Software shutdown from RUN: S_k is d = k + 1.
        sw = 1'b0;
        exp_at(1,  "sd_s0",  v(1, 1, 1, 0, 1, 0, 3'd6));
        exp_at(4,  "sd_s3",  v(1, 1, 1, 0, 1, 0, 3'd6));
        exp_at(5,  "sd_s4",  v(1, 1, 0, 0, 1, 0, 3'd6));
        exp_at(9,  "sd_s8",  v(1, 0, 0, 0, 1, 0, 3'd6));
        exp_at(13, "sd_s12", v(0, 0, 0, 0, 1, 0, 3'd6));
        exp_at(16, "sd_s15", v(0, 0, 0, 0, 1, 0, 3'd6));
        exp_at(17, "sd_s16", v(0, 0, 0, 0, 0, 0, 3'd0));
        drain();

        // Debounce glitch: pwr_good low one cycle, seen by the FSM when the count is 10.
        sw = 1'b1;
        exp_at(1, "gl_deb", v(0, 0, 0, 0, 1, 0, 3'd1));
        drain();
        tick(8);
        pg = 1'b0;
        tick(1);
        pg = 1'b1;
        exp_at(1,  "gl_still_deb", v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(2,  "gl_off",       v(0, 0, 0, 0, 0, 0, 3'd0));
        exp_at(3,  "gl_redeb",     v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(18, "gl_full16",    v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(19, "gl_iso",       v(1, 0, 0, 0, 1, 0, 3'd2));
        exp_at(31, "gl_run",       v(1, 1, 1, 1, 0, 0, 3'd5));
        drain();

        // Fault in RUN; no restart until cleared.
        hi = 1'b0;
        exp_at(1, "flt_run", v(0, 0, 0, 0, 0, 1, 3'd0));
        tick(1);
        hi = 1'b1;
        exp_at(5, "flt_hold", v(0, 0, 0, 0, 0, 1, 3'd0));
        drain();
        clear_and_run("flt_restart");

        // Fault and clear on the same edge: set wins.
        hi = 1'b0; clr = 1'b1;
        exp_at(1, "flt_clr_same", v(0, 0, 0, 0, 0, 1, 3'd0));
        tick(1);
        hi = 1'b1; clr = 1'b0;
        exp_at(3, "flt_clr_hold", v(0, 0, 0, 0, 0, 1, 3'd0));
        drain();
        clear_and_run("flt2_restart");

        // Re-enable mid-shutdown is ignored until OFF.
        sw = 1'b0;
        exp_at(1, "re_sd", v(1, 1, 1, 0, 1, 0, 3'd6));
        tick(6);
        sw = 1'b1;
        exp_at(7,  "re_s12",  v(0, 0, 0, 0, 1, 0, 3'd6));
        exp_at(10, "re_s15",  v(0, 0, 0, 0, 1, 0, 3'd6));
        exp_at(11, "re_off",  v(0, 0, 0, 0, 0, 0, 3'd0));
        exp_at(12, "re_deb",  v(0, 0, 0, 0, 1, 0, 3'd1));
        drain();

        // Reset while in LA_ON.
        exp_at(24, "rst_la_on", v(1, 1, 1, 0, 1, 0, 3'd4));
        drain();
        rst = 1'b1;
        exp_at(1, "rst_mid", v(0, 0, 0, 0, 0, 0, 3'd0));
        tick(1);
        rst = 1'b0;
        exp_at(2,  "rst_sync_off", v(0, 0, 0, 0, 0, 0, 3'd0));
        exp_at(3,  "rst_deb",      v(0, 0, 0, 0, 1, 0, 3'd1));
        exp_at(31, "rst_run",      v(1, 1, 1, 1, 0, 0, 3'd5));
        drain();

        // Fault and shutdown request together: fault wins.
        sw = 1'b0; hi = 1'b0;
`ifdef MPRJ2_SEQ_FAULT_CNT_EN
        exp_cnt(1, "prio_fault", v(0, 0, 0, 0, 0, 1, 3'd0), 8'd1);
`else
        exp_at(1, "prio_fault", v(0, 0, 0, 0, 0, 1, 3'd0));
`endif
        tick(1);
        hi = 1'b1;
        drain();

`ifdef MPRJ2_SEQ_FAULT_CNT_EN
        // 300 further faults, each raised from ISO_REL: counter saturates.
        sw = 1'b1;
        for (int k = 0; k < 300; k++) begin
            clr = 1'b1;
            tick(1);
            clr = 1'b0;
            tick(17);
            hi = 1'b0;
            tick(1);
            hi = 1'b1;
        end
        exp_cnt(1, "cnt_sat", v(0, 0, 0, 0, 0, 1, 3'd0), 8'd255);
        drain();
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
